cafea_fsm: RTL and testbench



---
 rtl/cafea_pkg.sv | 27 ++
 rtl/cafea_btn_edge.sv | 17 +
 rtl/cafea_fsm.sv | 99 +++++++++
 tb/tb_cafea_fsm.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cafea_pkg.sv
// cafea_pkg: shared encodings, default durations and state packing for the coffee-machine controller.
package cafea_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAT = 2'd1,
        POUR = 2'd2,
        DONE = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        ESP   = 2'd1,
        LONG  = 2'd2,
        WATER = 2'd3
    } sel_t;

    localparam int HEAT_CYC_DEF  = 4;
    localparam int SHORT_CYC_DEF = 3;
    localparam int LONG_CYC_DEF  = 6;
    localparam int DONE_CYC_DEF  = 2;

    function automatic logic [3:0] pack_state(sel_t s, phase_t p);
        return {s, p};
    endfunction

endpackage

// File: rtl/cafea_btn_edge.sv
// cafea_btn_edge: rising-edge press detection on the three front-panel buttons.
module cafea_btn_edge (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn,
    output logic [2:0] press
);

    logic [2:0] prev;

    always_ff @(posedge clk or negedge reset)
        if (!reset) prev <= 3'b000;
        else        prev <= btn;

    assign press = btn & ~prev;

endmodule

// File: rtl/cafea_fsm.sv
// cafea_fsm: sequences boiler heater and dispensing valves through heat/pour/done
// phases for the selected drink; state exposes {sel, phase}.
module cafea_fsm
    import cafea_pkg::*;
#(
    parameter int HEAT_CYC  = HEAT_CYC_DEF,
    parameter int SHORT_CYC = SHORT_CYC_DEF,
    parameter int LONG_CYC  = LONG_CYC_DEF,
    parameter int DONE_CYC  = DONE_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       B1,
    input  logic       B2,
    input  logic       B3,
    output logic [3:0] state,
    output logic       EB,
    output logic       ER1,
    output logic       ER2
);

    localparam logic [7:0] HEAT_LD  = 8'(HEAT_CYC - 1);
    localparam logic [7:0] SHORT_LD = 8'(SHORT_CYC - 1);
    localparam logic [7:0] LONG_LD  = 8'(LONG_CYC - 1);
    localparam logic [7:0] DONE_LD  = 8'(DONE_CYC - 1);

    phase_t     phase, nphase;
    sel_t       sel, nsel;
    logic [7:0] cnt, ncnt;
    logic [2:0] press;
    logic       abort;

    cafea_btn_edge u_btn (
        .clk   (clk),
        .reset (reset),
        .btn   ({B3, B2, B1}),
        .press (press)
    );

    // B1+B2 held together cancels an active brew and beats counter expiry
    assign abort = B1 & B2 & (phase == HEAT || phase == POUR);

    always_comb begin
        nphase = phase;
        nsel   = sel;
        ncnt   = cnt - 8'd1;
        case (phase)
            IDLE: begin
                nsel   = press[0] ? ESP : press[1] ? LONG : press[2] ? WATER : NONE;
                nphase = |press ? HEAT : IDLE;
                ncnt   = |press ? HEAT_LD : cnt;
            end
            HEAT: begin
                if (abort) begin
                    nphase = DONE;
                    ncnt   = DONE_LD;
                end else if (cnt == 8'd0) begin
                    nphase = POUR;
                    ncnt   = (sel == ESP) ? SHORT_LD : LONG_LD;
                end
            end
            POUR: begin
                if (abort || cnt == 8'd0) begin
                    nphase = DONE;
                    ncnt   = DONE_LD;
                end
            end
            DONE: begin
                if (cnt == 8'd0) begin
                    nphase = IDLE;
                    nsel   = NONE;
                    ncnt   = 8'd0;
                end
            end
            default: begin
                nphase = IDLE;
                nsel   = NONE;
                ncnt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            phase <= IDLE;
            sel   <= NONE;
            cnt   <= 8'd0;
        end else begin
            phase <= nphase;
            sel   <= nsel;
            cnt   <= ncnt;
        end

    assign state = pack_state(sel, phase);
    assign EB    = (phase == HEAT);
    assign ER1   = (phase == POUR) && (sel == ESP || sel == LONG);
    assign ER2   = (phase == POUR) && (sel == WATER);

endmodule

// File: tb/tb_cafea_fsm.sv
// tb_cafea_fsm: directed and random button traffic checked against a timeline model of a brew.
module tb_cafea_fsm;

    localparam int H = 4;
    localparam int S = 3;
    localparam int L = 6;
    localparam int D = 2;

    logic       clk, reset, B1, B2, B3;
    logic [3:0] state;
    logic       EB, ER1, ER2;

    int errors = 0;
    int checks = 0;

    // model: a brew is a timeline measured in cycles since the accepting edge
    int         busy, drink, k, ab;
    logic [2:0] mprev;

    cafea_fsm dut (
        .clk   (clk),
        .reset (reset),
        .B1    (B1),
        .B2    (B2),
        .B3    (B3),
        .state (state),
        .EB    (EB),
        .ER1   (ER1),
        .ER2   (ER2)
    );

    initial begin
        clk = 0;
        #2;
        forever #5 clk = ~clk;
    end

    function automatic int mphase();
        int p;
        p = (drink == 1) ? S : L;
        if (busy == 0) return 0;
        if (ab >= 0) return (k < ab + D) ? 3 : 0;
        return (k < H) ? 1 : (k < H + p) ? 2 : (k < H + p + D) ? 3 : 0;
    endfunction

    task automatic model_reset();
        busy = 0; drink = 0; k = 0; ab = -1; mprev = 3'b000;
    endtask

    task automatic model_edge(input logic [2:0] b);
        logic [2:0] pr;
        int ph;
        pr = b & ~mprev;
        mprev = b;
        if (busy == 0) begin
            if (pr != 3'b000) begin
                busy = 1; k = 0; ab = -1;
                drink = pr[0] ? 1 : pr[1] ? 2 : 3;
            end
        end else begin
            ph = mphase();
            if ((ph == 1 || ph == 2) && b[0] && b[1]) ab = k + 1;
            k++;
            if (mphase() == 0) busy = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int ph;
        ph = mphase();
        chk("state", 8'(state), (busy != 0) ? 8'(drink * 4 + ph) : 8'h0);
        chk("EB", 8'(EB), 8'(ph == 1));
        chk("ER1", 8'(ER1), 8'(ph == 2 && drink != 3));
        chk("ER2", 8'(ER2), 8'(ph == 2 && drink == 3));
        chk("excl", 8'(EB && (ER1 || ER2)), 8'h0);
    endtask

    task automatic step(input logic b1, input logic b2, input logic b3);
        @(negedge clk);
        B1 = b1; B2 = b2; B3 = b3;
        @(posedge clk);
        model_edge({b3, b2, b1});
        #1;
        check_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    initial begin
        B1 = 0; B2 = 0; B3 = 0;
        reset = 0;
        model_reset();
        #1;
        chk("rst_state", 8'(state), 8'h0);
        chk("rst_out", 8'({EB, ER1, ER2}), 8'h0);
        #14 reset = 1;
        idle_steps(4);
        chk("idle_state", 8'(state), 8'h0);

        step(0, 0, 1);
        chk("b3_heat", 8'(state), 8'hD);
        for (int i = 0; i < 14; i++) step(0, 0, 1);
        chk("b3_held_idle", 8'(state), 8'h0);
        idle_steps(3);

        step(1, 0, 0);
        chk("b1_heat", 8'(state), 8'h5);
        idle_steps(4);
        chk("b1_pour", 8'(state), 8'h6);
        chk("b1_er1", 8'(ER1), 8'h1);
        idle_steps(3);
        chk("b1_done", 8'(state), 8'h7);
        idle_steps(2);
        chk("b1_idle", 8'(state), 8'h0);
        idle_steps(2);

        step(1, 1, 1);
        chk("all_esp", 8'(state), 8'h5);
        step(0, 0, 0);
        step(0, 1, 0);
        chk("b2_ignored", 8'(state), 8'h5);
        idle_steps(12);

        step(0, 1, 0);
        chk("b2_heat", 8'(state), 8'h9);
        idle_steps(4);
        chk("b2_pour", 8'(state), 8'hA);
        step(1, 1, 0);
        chk("abort_state", 8'(state), 8'hB);
        chk("abort_er1", 8'(ER1), 8'h0);
        idle_steps(2);
        chk("abort_idle", 8'(state), 8'h0);
        idle_steps(2);

        step(0, 0, 1);
        idle_steps(5);
        chk("pre_rst_pour", 8'(state), 8'hE);
        @(negedge clk);
        #2 reset = 0;
        #1;
        model_reset();
        chk("async_state", 8'(state), 8'h0);
        chk("async_out", 8'({EB, ER1, ER2}), 8'h0);
        @(negedge clk);
        reset = 1;
        idle_steps(2);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
